// File: rtl/hls_macc_sched.sv
// hls_macc_sched: round-robin front end sharing one ap_ctrl_hs MACC core between N_REQ requesters.
// Optional RUN watchdog enabled by defining HLS_MACC_SCHED_TIMEOUT_EN.
module hls_macc_sched #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*5*DW-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2:0]              rsp_id,
    output logic [DW-1:0]           rsp_o1,
    output logic [DW-1:0]           rsp_o2,
    output logic [1:0]              rsp_err,
    output logic                    ap_start,
    input  logic                    ap_done,
    input  logic                    ap_ready,
    input  logic                    ap_idle,
    output logic [DW-1:0]           dp_i1,
    output logic [DW-1:0]           dp_i2,
    output logic [DW-1:0]           dp_i3,
    output logic [DW-1:0]           dp_i4,
    output logic [DW-1:0]           dp_i6,
    input  logic [DW-1:0]           o1,
    input  logic [DW-1:0]           o2,
    input  logic                    o1_ap_vld,
    input  logic                    o2_ap_vld
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned OW = 5 * DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [OW-1:0]   gnt_data;
    logic            f1;
    logic            f2;
    logic            wd_hit;

    // ap_ready is coincident with ap_done for this core and carries no extra information
    logic unused_ok;

`ifdef HLS_MACC_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    assign unused_ok = ap_ready;
    assign wd_hit    = (state == S_RUN) && !ap_done && (32'(wd_cnt) == TIMEOUT - 1);

    // Cycles spent in RUN for the current operation
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt <= '0;
        end else if (state != S_RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    assign unused_ok = ap_ready ^ (^32'(TIMEOUT));
    assign wd_hit    = 1'b0;
`endif

    // First requesting index at or above rr_ptr, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[(32'(rr_ptr) + i) % N_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign gnt_data = req_data[32'(gnt_idx) * OW +: OW];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        ap_start  = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    state_nxt = S_RUN;
                    req_ready = ap_rst_n ? (N_REQ'(1) << gnt_idx) : '0;
                end
            end
            S_RUN: begin
                ap_start = 1'b1;
                if (ap_done || wd_hit) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch on accept, result capture during RUN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_o1    <= '0;
            rsp_o2    <= '0;
            rsp_err   <= '0;
            f1        <= 1'b0;
            f2        <= 1'b0;
            dp_i1     <= '0;
            dp_i2     <= '0;
            dp_i3     <= '0;
            dp_i4     <= '0;
            dp_i6     <= '0;
        end else begin
            rsp_valid <= (state_nxt == S_RESP);
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        {dp_i6, dp_i4, dp_i3, dp_i2, dp_i1} <= gnt_data;
                        rsp_id  <= 3'(gnt_idx);
                        rr_ptr  <= (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + PW'(1);
                        rsp_o1  <= '0;
                        rsp_o2  <= '0;
                        rsp_err <= '0;
                        f1      <= 1'b0;
                        f2      <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (o1_ap_vld) begin
                        rsp_o1 <= o1;
                        f1     <= 1'b1;
                    end
                    if (o2_ap_vld) begin
                        rsp_o2 <= o2;
                        f2     <= 1'b1;
                    end
                    if (ap_done) begin
                        rsp_err[0] <= !(f1 || o1_ap_vld) || !(f2 || o2_ap_vld);
                    end else if (wd_hit) begin
                        rsp_err[1] <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_idle_on_accept: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (state == S_IDLE && gnt_any) |-> ap_idle);

endmodule

// File: tb/tb_hls_macc_sched.sv
// Scoreboard bench for hls_macc_sched with a 4-state ap_ctrl_hs MACC core model.
module tb_hls_macc_sched;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic [2:0]    id;
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        logic [1:0]    err;
        logic [1:0]    mask;
    } exp_t;

    logic                  ap_clk = 1'b0;
    logic                  ap_rst_n;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*5*DW-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2:0]            rsp_id;
    logic [DW-1:0]         rsp_o1, rsp_o2;
    logic [1:0]            rsp_err;
    logic                  ap_start, ap_done, ap_ready, ap_idle;
    logic [DW-1:0]         dp_i1, dp_i2, dp_i3, dp_i4, dp_i6;
    logic [DW-1:0]         o1, o2;
    logic                  o1_ap_vld, o2_ap_vld;

    logic [DW-1:0] opnd [N_REQ][5];
    int   remaining [N_REQ];
    exp_t sb [$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   last_grant = -1;
    int   exp_lat = 5;
    int   exp_ptr = 0;
    bit   spacing_en = 1'b0;
    bit   prev_valid = 1'b0;
    bit   fixed_mode, en_o1, en_o2, hang;

    always #5 ap_clk = ~ap_clk;

    for (genvar k = 0; k < N_REQ; k++) begin : g_rd
        for (genvar j = 0; j < 5; j++) begin : g_op
            assign req_data[(k*5+j)*DW +: DW] = opnd[k][j];
        end
    end

    hls_macc_sched #(.N_REQ(N_REQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_o1(rsp_o1), .rsp_o2(rsp_o2), .rsp_err(rsp_err),
        .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready), .ap_idle(ap_idle),
        .dp_i1(dp_i1), .dp_i2(dp_i2), .dp_i3(dp_i3), .dp_i4(dp_i4), .dp_i6(dp_i6),
        .o1(o1), .o2(o2), .o1_ap_vld(o1_ap_vld), .o2_ap_vld(o2_ap_vld)
    );

    // Core model: start sampled in state1, results and done in state4
    logic [1:0] cs;
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)       cs <= 2'd0;
        else if (cs == 2'd0) cs <= ap_start ? 2'd1 : 2'd0;
        else if (cs == 2'd3) cs <= hang ? 2'd3 : 2'd0;
        else                 cs <= cs + 2'd1;
    end
    assign ap_done   = (cs == 2'd3) && !hang;
    assign ap_ready  = ap_done;
    assign ap_idle   = (cs == 2'd0);
    assign o1_ap_vld = ap_done && en_o1;
    assign o2_ap_vld = ap_done && en_o2;
    assign o1 = fixed_mode ? DW'(32'h100) : dp_i1 * dp_i2 + dp_i3;
    assign o2 = fixed_mode ? DW'(32'h200) : dp_i4 * dp_i6 - dp_i1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input int g);
        exp_t e;
        logic [DW-1:0] a1, a2;
        e.id = 3'(g);
        if (fixed_mode) begin
            a1 = DW'(32'h100);
            a2 = DW'(32'h200);
        end else begin
            a1 = opnd[g][0] * opnd[g][1] + opnd[g][2];
            a2 = opnd[g][3] * opnd[g][4] - opnd[g][0];
        end
        e.mask = 2'b11;
        if (hang) begin
            e.o1 = '0; e.o2 = '0; e.err = 2'b10; e.mask = 2'b10;
        end else begin
            e.o1  = en_o1 ? a1 : '0;
            e.o2  = en_o2 ? a2 : '0;
            e.err = {1'b0, !(en_o1 && en_o2)};
        end
        return e;
    endfunction

    task automatic load(input int k);
        for (int j = 0; j < 5; j++) opnd[k][j] = DW'($urandom);
        req_valid[k] = 1'b1;
    endtask

    // One clock: observe at negedge, then update requesters just after posedge
    task automatic cycle();
        logic [N_REQ-1:0] taken;
        exp_t e;
        int g, eg, k;
        taken = '0;
        @(negedge ap_clk);
        cyc++;
        if (rsp_valid || |req_ready) check("start_outside_run", 64'(ap_start), 64'd0);
        if (|req_ready) begin
            g = 0;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
            eg = -1;
            for (int i = 0; i < N_REQ; i++) begin
                k = (exp_ptr + i) % N_REQ;
                if (eg < 0 && req_valid[k]) eg = k;
            end
            check("grant_onehot", 64'($countones(req_ready)), 64'd1);
            check("grant_idx", 64'(g), 64'(eg));
            if (spacing_en && last_grant >= 0) check("grant_gap", 64'(cyc - last_grant), 64'd6);
            last_grant = cyc;
            last_acc   = cyc;
            exp_ptr    = (g + 1) % N_REQ;
            sb.push_back(make_exp(g));
            taken[g] = 1'b1;
        end
        if (rsp_valid) begin
            check("no_grant_in_resp", 64'(req_ready), 64'd0);
            if (!prev_valid) check("latency", 64'(cyc - last_acc), 64'(exp_lat));
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb[0];
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_o1", 64'(rsp_o1), 64'(e.o1));
                check("rsp_o2", 64'(rsp_o2), 64'(e.o2));
                check("rsp_err", 64'(rsp_err & e.mask), 64'(e.err));
                if (rsp_ready) void'(sb.pop_front());
            end
        end
        prev_valid = rsp_valid;
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (taken[i]) begin
                if (remaining[i] > 0) begin
                    remaining[i]--;
                    load(i);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || |req_valid || rsp_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", 64'(sb.size() + (|req_valid ? 1 : 0)), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_id"},    64'(rsp_id),    64'd0);
        check({tag, "_rsp_o1"},    64'(rsp_o1),    64'd0);
        check({tag, "_rsp_o2"},    64'(rsp_o2),    64'd0);
        check({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        check({tag, "_ap_start"},  64'(ap_start),  64'd0);
        check({tag, "_dp"}, 64'(dp_i1 | dp_i2 | dp_i3 | dp_i4 | dp_i6), 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        ap_rst_n   = 1'b0;
        rsp_ready  = 1'b1;
        req_valid  = '0;
        fixed_mode = 1'b0;
        en_o1      = 1'b1;
        en_o2      = 1'b1;
        hang       = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            remaining[k] = 0;
            for (int j = 0; j < 5; j++) opnd[k][j] = '0;
        end

        // All requesters valid from reset; requester 0 gets a second operation
        for (int k = 0; k < N_REQ; k++) load(k);
        remaining[0] = 1;
        repeat (3) @(negedge ap_clk);
        check_zero("reset");
        @(posedge ap_clk);
        #1;
        ap_rst_n   = 1'b1;
        spacing_en = 1'b1;
        last_grant = -1;
        drain(100);
        spacing_en = 1'b0;

        // Single request with fixed core results
        fixed_mode = 1'b1;
        opnd[2][0] = DW'(3);
        opnd[2][1] = DW'(5);
        opnd[2][2] = DW'(7);
        opnd[2][3] = DW'(11);
        opnd[2][4] = DW'(13);
        req_valid[2] = 1'b1;
        drain(50);
        fixed_mode = 1'b0;

        // Backpressure while another requester waits
        rsp_ready = 1'b0;
        load(3);
        load(0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        repeat (10) cycle();
        rsp_ready = 1'b1;
        drain(50);

        // Missing o2 strobe
        en_o2 = 1'b0;
        load(1);
        drain(50);
        en_o2 = 1'b1;

        // Reset in cycle 3 of a run
        load(2);
        repeat (3) cycle();
        ap_rst_n = 1'b0;
        #1;
        check_zero("midrst");
        sb.delete();
        exp_ptr = 0;
        repeat (2) cycle();
        ap_rst_n = 1'b1;
        load(1);
        load(3);
        drain(60);

        // Core that never finishes
        hang = 1'b1;
        load(0);
`ifdef HLS_MACC_SCHED_TIMEOUT_EN
        exp_lat = TIMEOUT + 1;
        drain(TIMEOUT + 20);
        exp_lat = 5;
`else
        seen = 0;
        repeat (1000) begin
            cycle();
            if (rsp_valid) seen++;
        end
        check("hang_no_rsp", 64'(seen), 64'd0);
`endif
        ap_rst_n = 1'b0;
        sb.delete();
        repeat (2) cycle();
        hang     = 1'b0;
        ap_rst_n = 1'b1;
        exp_ptr  = 0;
        cycle();
        check_zero("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hls_macc_sched.md
# hls_macc_sched

Round-robin scheduler that shares one HLS multiply-accumulate core (ap_ctrl_hs: `ap_start`/`ap_done`/`ap_idle`/`ap_ready`, 32-bit operands i1,i2,i3,i4,i6 and results o1/o2 with per-output `_ap_vld` strobes) between `N_REQ` requesters. It accepts one operand set at a time, holds it stable on the core inputs for the whole run, and sequences the core's start/done handshake. It captures both results and returns them with the requester ID over a valid/ready response port. It sits between the request fabric and the locked MACC datapath; the core's key inputs are wired outside this block.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `DW`, 32, operand/result width.
- `TIMEOUT`, 64, watchdog limit in cycles. Used only with `HLS_MACC_SCHED_TIMEOUT_EN`.

- `ap_clk`  in  1  clock, all logic on rising edge.
- `ap_rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester request.
- `req_ready`  out  N_REQ  one-hot grant/accept.
- `req_data`  in  N_REQ*5*DW  per-requester operands. Requester k occupies slice [k*5*DW +: 5*DW], packed {i6,i4,i3,i2,i1} with i1 in the LSBs.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  3  requester index of the result.
- `rsp_o1`, `rsp_o2`  out  DW  captured results.
- `rsp_err`  out  2  [0] missing result strobe, [1] watchdog timeout.
- `ap_start`  out  1  core start.
- `ap_done`, `ap_ready`, `ap_idle`  in  1  core status.
- `dp_i1`, `dp_i2`, `dp_i3`, `dp_i4`, `dp_i6`  out  DW  core operands.
- `o1`, `o2`  in  DW  core results.
- `o1_ap_vld`, `o2_ap_vld`  in  1  core result strobes.

## Operation
- FSM has three states: IDLE, RUN, RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first set bit searching upward (with wrap) from `rr_ptr`.
  - `req_ready[g]` is 1 in this cycle only, combinationally.
  - On the clock edge, latch `req_data` slice g into the operand registers, latch `rsp_id`=g, set `rr_ptr`=(g+1) mod N_REQ, clear the capture flags, and go to RUN.
- **RUN:**
  - `ap_start`=1, driven combinationally from the state.
  - Operand registers are frozen.
  - When `o1_ap_vld` is high, capture `o1` into `rsp_o1` and set flag f1. `o2`/f2 are handled the same way.
  - When `ap_done` is high, go to RESP. Set `rsp_err[0]` if either strobe was not seen in the run, including the `ap_done` cycle itself.
  - `ap_ready` is ignored, since it is coincident with `ap_done` for this core.
- **RESP:**
  - `rsp_valid`=1 and `ap_start`=0.
  - On `rsp_valid & rsp_ready`, go to IDLE. The next grant can happen in the cycle after that.
- While a request is outstanding, requesters that are not granted see `req_ready`=0 and must hold `req_valid` and their data.
- `ap_idle` is unused except in checkers; an assertion fires if RUN is entered with `ap_idle`=0.
- Reset values:
  - All outputs 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_o1`, `rsp_o2`, `rsp_err`, `ap_start`, `dp_*`.
  - FSM=IDLE, `rr_ptr`=0.
- Reset asserted mid-run aborts immediately: no response is issued and the operation is lost. The core must share the same reset domain.
- All arithmetic is in the core; this block only does index arithmetic (mod N_REQ).

## Timing
- Cycle 0: accept, in IDLE.
- Cycle 1: `ap_start`=1 and the core's state1 samples it.
- Cycles 2 and 3: core states 2 and 3.
- Cycle 4: core state4, with `ap_done`/`o1_ap_vld`/`o2_ap_vld` high.
- Cycle 5: RESP, `rsp_valid`=1.
- Accept-to-`rsp_valid` is 5 cycles. With `rsp_ready` held high, throughput is one operation per 6 cycles.
- `ap_start` falls in the cycle after `ap_done`, so the core returns to idle and never restarts spuriously.
- A `req_valid` that rises while the block is in RESP waits until IDLE.
- `rsp_*` outputs are registered and stable while `rsp_valid`=1 and `rsp_ready`=0.

## Configuration
- `HLS_MACC_SCHED_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN.
  - If `ap_done` has not arrived after TIMEOUT cycles in RUN, go to RESP with `rsp_err[1]`=1 and `rsp_o1`/`rsp_o2` holding whatever was captured (0 if nothing was captured).
  - `ap_start` drops, as in a normal RESP.
- Not defined: no counter; RUN waits for `ap_done` indefinitely; `rsp_err[1]` is tied to 0.

## Test plan
- Single request: requester 2 with i1=3, i2=5, i3=7, i4=11, i6=13, using a core model that returns o1=0x100, o2=0x200 -> `rsp_valid` 5 cycles after accept, `rsp_id`=2, `rsp_o1`=0x100, `rsp_o2`=0x200, `rsp_err`=0.
- All four requesters valid from reset, with `rsp_ready`=1 -> grants in order 0,1,2,3,0; grants are 6 cycles apart; `ap_start` is never high in RESP or IDLE.
- Backpressure: `rsp_ready`=0 for 10 cycles -> `rsp_valid` and data held stable, no new `req_ready`, and `ap_start` stays 0.
- Core model suppresses `o2_ap_vld` -> `rsp_err`=2'b01, `rsp_o1` correct, `rsp_o2`=0.
- With `HLS_MACC_SCHED_TIMEOUT_EN`, TIMEOUT=64 and a core that never asserts `ap_done` -> `rsp_valid` after 64 RUN cycles with `rsp_err[1]`=1. Without the macro, no response within 1000 cycles.
- `ap_rst_n` pulsed low in cycle 3 of a run -> all outputs 0 immediately; after release, a fresh request completes normally with `rr_ptr` back at 0.
